// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller side (master) consumes opcode and mem_ready and drives every enable and mux select.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle datapath: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Outputs decode the state register (and mem_ready in FETCH).
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus,
  output logic                 illegal_op,
  output logic [3:0]           state,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_RWB    = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state_nxt;
  logic       retire;

  // State register and retired-instruction counter; reset wins over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt       = ST_FETCH;
    retire          = 1'b0;
    illegal_op      = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;

    case (state)
      ST_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        state_nxt   = bus.mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Branch target precomputed here so BRANCH can compare in one cycle.
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          OP_RTYPE:    state_nxt = ST_EXEC;
          OP_LW, OP_SW: state_nxt = ST_MEMADR;
          OP_BEQ:      state_nxt = ST_BRANCH;
          OP_J:        state_nxt = ST_JUMP;
          default: begin
            state_nxt  = ST_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_nxt   = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_nxt   = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        retire       = 1'b1;
      end
      ST_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        retire       = bus.mem_ready;
        state_nxt    = bus.mem_ready ? ST_FETCH : ST_MEMWR;
      end
      ST_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_nxt   = ST_RWB;
      end
      ST_RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        retire       = 1'b1;
      end
      ST_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        retire          = 1'b1;
      end
      ST_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        retire       = 1'b1;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed steps push expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

  localparam int unsigned CW = 4;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]    st;
    logic [15:0]   ctl;
    logic          ill;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          illegal_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_control_if bus ();

  multicycle_control #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .illegal_op  (illegal_op),
    .state       (state),
    .instr_count (instr_count)
  );

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word, order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0].
  function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr);
    case (st)
      4'd0:    exp_ctl = mr ? 16'h9410 : 16'h1010;
      4'd1:    exp_ctl = 16'h0030;
      4'd2:    exp_ctl = 16'h0060;
      4'd3:    exp_ctl = 16'h3000;
      4'd4:    exp_ctl = 16'h0280;
      4'd5:    exp_ctl = 16'h2800;
      4'd6:    exp_ctl = 16'h0048;
      4'd7:    exp_ctl = 16'h0180;
      4'd8:    exp_ctl = 16'h4045;
      4'd9:    exp_ctl = 16'h8002;
      default: exp_ctl = 16'h0000;
    endcase
  endfunction

  // Drive one cycle of inputs, record what the DUT must show during it, advance one clock.
  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic ill, input logic [CW-1:0] cnt);
    exp_t e;
    reset         = rst;
    bus.opcode    = op;
    bus.mem_ready = mr;
    e.st  = st;
    e.ctl = exp_ctl(st, mr);
    e.ill = ill;
    e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with an expectation outstanding is compared at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = q.pop_front();
      act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
             bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
             bus.PCSource};
      checks += 4;
      if (state !== e.st) begin
        failures++;
        $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e.st);
      end
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl t=%0t st=%0d got=%h exp=%h", $time, e.st, act, e.ctl);
      end
      if (illegal_op !== e.ill) begin
        failures++;
        $display("FAIL illegal_op t=%0t got=%b exp=%b", $time, illegal_op, e.ill);
      end
      if (instr_count !== e.cnt) begin
        failures++;
        $display("FAIL instr_count t=%0t got=%0d exp=%0d", $time, instr_count, e.cnt);
      end
      checks++;
      if (bus.PCSource === 2'b11) begin
        failures++;
        $display("FAIL pcsource_11 t=%0t got=%b exp=not 11", $time, bus.PCSource);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // R-type: 0,1,6,7 then FETCH with count 1 (FETCH doubles as first cycle of lw).
    step(0, OP_R, 1, 4'd0, 0, 0);
    step(0, OP_R, 1, 4'd1, 0, 0);
    step(0, OP_R, 1, 4'd6, 0, 0);
    step(0, OP_R, 1, 4'd7, 0, 0);

    // lw with three wait cycles in MEMRD: 0,1,2,3,3,3,3,4.
    step(0, OP_LW, 1, 4'd0, 0, 1);
    step(0, OP_LW, 1, 4'd1, 0, 1);
    step(0, OP_LW, 1, 4'd2, 0, 1);
    step(0, OP_LW, 0, 4'd3, 0, 1);
    step(0, OP_LW, 0, 4'd3, 0, 1);
    step(0, OP_LW, 0, 4'd3, 0, 1);
    step(0, OP_LW, 1, 4'd3, 0, 1);
    step(0, OP_LW, 1, 4'd4, 0, 1);

    // sw with one write wait cycle.
    step(0, OP_SW, 1, 4'd0, 0, 2);
    step(0, OP_SW, 1, 4'd1, 0, 2);
    step(0, OP_SW, 1, 4'd2, 0, 2);
    step(0, OP_SW, 0, 4'd5, 0, 2);
    step(0, OP_SW, 1, 4'd5, 0, 2);

    // beq.
    step(0, OP_BEQ, 1, 4'd0, 0, 3);
    step(0, OP_BEQ, 1, 4'd1, 0, 3);
    step(0, OP_BEQ, 1, 4'd8, 0, 3);

    // j, with one fetch wait cycle first.
    step(0, OP_J, 0, 4'd0, 0, 4);
    step(0, OP_J, 1, 4'd0, 0, 4);
    step(0, OP_J, 1, 4'd1, 0, 4);
    step(0, OP_J, 1, 4'd9, 0, 4);

    // Unsupported opcode: one-cycle illegal_op in DECODE, back to FETCH, not counted.
    step(0, OP_BAD, 1, 4'd0, 0, 5);
    step(0, OP_BAD, 1, 4'd1, 1, 5);
    step(0, OP_BAD, 1, 4'd0, 0, 5);
    step(0, OP_BAD, 1, 4'd1, 1, 5);

    // Reset while stalled in MEMRD abandons the access and clears the count.
    step(0, OP_LW, 1, 4'd0, 0, 5);
    step(0, OP_LW, 1, 4'd1, 0, 5);
    step(0, OP_LW, 1, 4'd2, 0, 5);
    step(0, OP_LW, 0, 4'd3, 0, 5);
    step(1, OP_LW, 0, 4'd3, 0, 5);
    step(0, OP_J, 1, 4'd0, 0, 0);

    // Sixteen jumps take the 4-bit counter through all-ones and wrap it to zero.
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step(0, OP_J, 1, 4'd0, 0, CW'(i));
      step(0, OP_J, 1, 4'd1, 0, CW'(i));
      step(0, OP_J, 1, 4'd9, 0, CW'(i));
    end
    step(0, OP_J, 1, 4'd0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multi-cycle datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable and every mux select, including the 2-bit PCSource select of the 3-input PC-source mux and the 2-bit ALUSrcB select.
- Sits directly upstream of those muxes. Consumes the IR opcode and a memory-ready handshake.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26] of the current instruction
- mem_ready  input  1  memory has completed the current read or write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU zero (beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
- ALUOp  output  2  00 = add, 01 = subtract, 10 = use funct field
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target; never 11
- illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported
- state  output  4  current state encoding, for debug
- instr_count  output  CNT_W  count of completed instructions

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9
  - Codes 10–15 are unused.
- Reset:
  - On a clock edge with reset = 1: state = FETCH and instr_count = 0, regardless of the current state. An in-flight memory access is abandoned.
  - Outputs are a pure decode of state (plus mem_ready where noted). After reset they therefore take FETCH values.
- Default for every output: 0, unless listed for the current state below.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = mem_ready and PCWrite = mem_ready.
  - Stays in FETCH while mem_ready = 0. Goes to DECODE when mem_ready = 1.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target precompute).
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - any other opcode → FETCH, with illegal_op = 1 for this cycle only. The instruction is not counted.
- MEMADR:
  - ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
  - Goes to MEMRD if opcode = lw, else MEMWR.
- MEMRD:
  - MemRead = 1, IorD = 1.
  - Waits while mem_ready = 0. Goes to MEMWB when mem_ready = 1.
- MEMWB:
  - RegWrite = 1, MemtoReg = 1, RegDst = 0.
  - Goes to FETCH.
- MEMWR:
  - MemWrite = 1, IorD = 1.
  - Waits while mem_ready = 0. Goes to FETCH when mem_ready = 1.
- EXEC:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10.
  - Goes to RWB.
- RWB:
  - RegWrite = 1, RegDst = 1, MemtoReg = 0.
  - Goes to FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01.
  - Goes to FETCH.
- JUMP:
  - PCWrite = 1, PCSource = 10.
  - Goes to FETCH.
- Unused codes 10–15: all outputs 0; next state FETCH (self-recovery).
- Opcode is sampled only in DECODE and MEMADR. The datapath holds IR stable between instructions.
- instr_count:
  - Increments by 1 on the edge that leaves a final state to FETCH. Final states are MEMWB, MEMWR (with mem_ready = 1), RWB, BRANCH and JUMP.
  - Wraps modulo 2^CNT_W.
  - Reset takes priority over increment.
- Cycles per instruction with mem_ready always high: R = 4, lw = 5, sw = 4, beq = 3, j = 3. Each wait cycle on mem_ready adds 1.

Test Plan:
- Reset held 2 cycles, then released with mem_ready = 1 → state = 0, MemRead = 1, IRWrite = 1, PCWrite = 1, ALUSrcB = 01, instr_count = 0.
- opcode = 000000, mem_ready = 1 → state sequence 0, 1, 6, 7, 0. RegWrite = 1 and RegDst = 1 only in state 7. instr_count becomes 1 after 4 cycles.
- opcode = 100011, mem_ready low for 3 cycles in MEMRD → state sequence 0, 1, 2, 3, 3, 3, 3, 4, 0. IorD = 1 throughout state 3. MemtoReg = 1 in state 4. Total 8 cycles.
- opcode = 000100, then 000010 → BRANCH drives PCWriteCond = 1 and PCSource = 01. JUMP drives PCWrite = 1 and PCSource = 10. PCSource never equals 11 in any cycle.
- opcode = 111111 → illegal_op pulses for exactly 1 cycle in DECODE, then FETCH follows. instr_count is unchanged.
- Reset asserted while in MEMRD with mem_ready = 0 → state = 0 on the next edge and instr_count = 0. Preset instr_count to all-ones and complete one instruction → it wraps to 0.
